tone_direction_decoder: RTL and testbench
=========================================

# tone_direction_decoder

Qualifies the five band-pass tone-detector comparator outputs (bp1..bp5) into a single junction command for the drive state machine. It produces a held enable `td_en` plus a 2-bit direction `td_dir` (STRAIGHT/LEFT/RIGHT/BACK), which the drive controller consumes in its JUNCTION state. The drive controller acknowledges the command with `td_ack`. The block sits directly upstream of the drive state machine, between the analog tone front-end pins and the `tdEn`/`tdDir` nets.

## Interface
- `QUAL_CYCLES`, default 2_500_000: consecutive cycles (50 ms at 50 MHz) a tone must be solely present to qualify; also used for cancel qualification and rearm quiet time. Must be ≥ 2.
- `HOLD_CYCLES`, default 250_000_000: maximum cycles `td_en` stays high without `td_ack` (5 s).
- `CNT_W`, default 28: counter width; must hold `HOLD_CYCLES-1`.
- `clk` input 1: system clock, 50 MHz.
- `rst_n` input 1: asynchronous, active-low reset.
- `bp1` input 1: STRAIGHT tone present, active-high, asynchronous.
- `bp2` input 1: LEFT tone present.
- `bp3` input 1: RIGHT tone present.
- `bp4` input 1: BACK tone present.
- `bp5` input 1: CANCEL tone present.
- `td_ack` input 1: one-cycle pulse from the drive controller meaning the command has been executed.
- `td_en` output 1: command valid, level.
- `td_dir` output 2: 00 STRAIGHT, 01 LEFT, 10 RIGHT, 11 BACK.
- `td_conflict` output 1: one-cycle pulse when a qualification is aborted because a second tone appears.
- `td_timeout` output 1: one-cycle pulse when the hold time expires.

## Operation
- bp1..bp5 each pass through a 2-FF synchronizer, giving s1..s5. All logic below uses s*.
- Direction tones are s1..s4. "Sole candidate" means exactly one of s1..s4 is high and s5 is low.
- States:
  - IDLE: `td_en`=0. If there is a sole candidate, latch its code into `cand`, clear `qcnt`, and go to QUAL.
  - QUAL: If the `cand` tone is still the sole candidate, increment `qcnt`. When `qcnt`==QUAL_CYCLES-1, go to VALID, load `td_dir`←`cand`, and clear `hcnt`.
    - If the `cand` tone drops, go to IDLE with no pulse.
    - If another s1..s4 goes high, pulse `td_conflict` and go to IDLE.
  - VALID: `td_en`=1 and `td_dir` is stable. `hcnt` increments each cycle.
    - `td_ack`=1: go to REARM.
    - `hcnt`==HOLD_CYCLES-1: pulse `td_timeout` and go to REARM.
  - REARM: `td_en`=0. Clear `qcnt` whenever any of s1..s5 is high, otherwise increment it. When `qcnt`==QUAL_CYCLES-1, go to IDLE. This prevents the same still-sounding tone from retriggering.
- Cancel: a separate counter `ccnt` counts consecutive s5-high cycles and clears on s5 low. When `ccnt` reaches QUAL_CYCLES-1, the state goes to REARM from any state. `td_conflict` and `td_timeout` do not pulse on a cancel.
- Priority within one cycle: cancel > `td_ack` > timeout. Cancel and `td_ack` together go to REARM once, with no pulses. `td_ack` and timeout in the same cycle go to REARM with no `td_timeout` pulse.
- `td_ack` is ignored outside VALID.
- `td_dir` holds its last value after VALID is exited. It is only updated on entry to VALID.
- Counters saturate and never wrap. Comparisons use `==` on CNT_W-bit values.

## Timing
- Reset (asynchronous, immediate, including mid-operation) produces:
  - state=IDLE
  - `td_en`=0, `td_dir`=00, `td_conflict`=0, `td_timeout`=0
  - all counters 0, synchronizers 0
- All outputs are registered.
- Latency from the first clock edge sampling a bp pin high to `td_en`=1 is QUAL_CYCLES+3 edges: 2 synchronizer edges, 1 IDLE→QUAL edge, and QUAL_CYCLES edges in QUAL.
- `td_ack` sampled high at edge n gives `td_en`=0 after edge n.
- A timeout gives `td_en` high for exactly HOLD_CYCLES cycles.
- Minimum gap between commands is QUAL_CYCLES quiet cycles in REARM plus requalification.
- A candidate dropping for one cycle in QUAL restarts qualification from IDLE.

## Test plan
- QUAL=4, HOLD=20: hold bp3 high continuously. Expect `td_en` to rise at edge 7 after the first sample, with `td_dir`=10. Pulse `td_ack` at edge 10; expect `td_en`=0 after edge 10. With bp3 still high, `td_en` must not reassert.
- Hold bp2 high. Once `td_en`=1, never assert `td_ack`. Expect `td_en` high for exactly 20 cycles, then one `td_timeout` pulse, then `td_en`=0.
- Raise bp1, then raise bp4 two cycles later while still in QUAL. Expect one `td_conflict` pulse and `td_en` to stay 0.
- With bp4 at `td_en`=1 and `td_dir`=11: hold bp5 high. Expect `td_en`=0 four cycles after s5 rises, with no `td_timeout` or `td_conflict` pulse.
- Pulse bp1 high for 3 cycles, then low. Expect no `td_en`. Then drive bp1 high for 4+ cycles; expect `td_en`=1 with `td_dir`=00.
- Assert `rst_n`=0 asynchronously mid-VALID. Expect `td_en`=0 and `td_dir`=00 immediately, without waiting for a clock edge. After release with bp2 held high, expect `td_en` to rise QUAL+3 edges later.

Source files
------------

// File: rtl/tone_direction_decoder.sv
// tone_direction_decoder
//   Qualifies the five band-pass tone comparator outputs into one junction
//   command (enable + 2-bit direction) for the drive state machine.
//
//   Ports:
//     clk          system clock (50 MHz)
//     rst_n        asynchronous active-low reset
//     bp1..bp5     raw tone-present pins: STRAIGHT, LEFT, RIGHT, BACK, CANCEL
//     td_ack       one-cycle pulse from the drive controller, command done
//     td_en        command valid (level)
//     td_dir       00 STRAIGHT, 01 LEFT, 10 RIGHT, 11 BACK
//     td_conflict  one-cycle pulse, qualification aborted by a second tone
//     td_timeout   one-cycle pulse, hold time expired without ack
//
//   state | meaning
//   IDLE  | waiting for a sole direction tone
//   QUAL  | candidate tone must stay sole for QUAL_CYCLES cycles
//   VALID | command presented, waiting for ack or hold expiry
//   REARM | waiting for QUAL_CYCLES fully quiet cycles before accepting again
module tone_direction_decoder #(
  parameter int QUAL_CYCLES = 2_500_000,
  parameter int HOLD_CYCLES = 250_000_000,
  parameter int CNT_W       = 28
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       bp1,
  input  logic       bp2,
  input  logic       bp3,
  input  logic       bp4,
  input  logic       bp5,
  input  logic       td_ack,
  output logic       td_en,
  output logic [1:0] td_dir,
  output logic       td_conflict,
  output logic       td_timeout
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_QUAL  = 2'd1,
    ST_VALID = 2'd2,
    ST_REARM = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] QUAL_MAX = CNT_W'(QUAL_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  state_t           state_q, state_d;
  logic [4:0]       sync_meta_q, sync_q;
  logic [1:0]       cand_q, cand_d;
  logic [1:0]       dir_q, dir_d;
  logic [CNT_W-1:0] qcnt_q, qcnt_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0] ccnt_q, ccnt_d;
  logic             en_q, en_d;
  logic             conflict_q, conflict_d;
  logic             timeout_q, timeout_d;

  logic             sole;
  logic [1:0]       sole_code;
  logic [3:0]       cand_mask;
  logic             cand_hi;
  logic             other_hi;
  logic             any_hi;
  logic             cancel;

  // Sole-candidate detection on the synchronized tones.
  always_comb begin
    sole      = 1'b0;
    sole_code = 2'd0;
    if (!sync_q[4]) begin
      case (sync_q[3:0])
        4'b0001: begin sole = 1'b1; sole_code = 2'd0; end
        4'b0010: begin sole = 1'b1; sole_code = 2'd1; end
        4'b0100: begin sole = 1'b1; sole_code = 2'd2; end
        4'b1000: begin sole = 1'b1; sole_code = 2'd3; end
        default: begin sole = 1'b0; sole_code = 2'd0; end
      endcase
    end
  end

  assign cand_mask = 4'b0001 << cand_q;
  assign cand_hi   = |(sync_q[3:0] & cand_mask);
  assign other_hi  = |(sync_q[3:0] & ~cand_mask);
  assign any_hi    = |sync_q;
  // ccnt_q already holds QUAL_CYCLES-1 earlier high samples, so this is the
  // QUAL_CYCLES-th consecutive one.
  assign cancel    = sync_q[4] && (ccnt_q == QUAL_MAX);

  always_comb begin
    state_d    = state_q;
    cand_d     = cand_q;
    dir_d      = dir_q;
    qcnt_d     = qcnt_q;
    hcnt_d     = hcnt_q;
    conflict_d = 1'b0;
    timeout_d  = 1'b0;

    // Cancel counter holds at its terminal value while the tone persists.
    if (!sync_q[4])              ccnt_d = '0;
    else if (ccnt_q == QUAL_MAX) ccnt_d = ccnt_q;
    else                         ccnt_d = ccnt_q + ONE;

    case (state_q)
      ST_IDLE: begin
        if (sole) begin
          cand_d  = sole_code;
          qcnt_d  = '0;
          state_d = ST_QUAL;
        end
      end
      ST_QUAL: begin
        if (other_hi) begin
          conflict_d = 1'b1;
          state_d    = ST_IDLE;
        end else if (!cand_hi || sync_q[4]) begin
          // Candidate lost sole status: restart quietly.
          state_d = ST_IDLE;
        end else if (qcnt_q == QUAL_MAX) begin
          dir_d   = cand_q;
          hcnt_d  = '0;
          state_d = ST_VALID;
        end else begin
          qcnt_d = qcnt_q + ONE;
        end
      end
      ST_VALID: begin
        if (td_ack) begin
          qcnt_d  = '0;
          state_d = ST_REARM;
        end else if (hcnt_q == HOLD_MAX) begin
          timeout_d = 1'b1;
          qcnt_d    = '0;
          state_d   = ST_REARM;
        end else begin
          hcnt_d = hcnt_q + ONE;
        end
      end
      ST_REARM: begin
        if (any_hi)                  qcnt_d  = '0;
        else if (qcnt_q == QUAL_MAX) state_d = ST_IDLE;
        else                         qcnt_d  = qcnt_q + ONE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Cancel overrides everything and suppresses both pulses.
    if (cancel) begin
      state_d    = ST_REARM;
      qcnt_d     = '0;
      dir_d      = dir_q;
      conflict_d = 1'b0;
      timeout_d  = 1'b0;
    end

    en_d = (state_d == ST_VALID);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta_q <= '0;
      sync_q      <= '0;
      state_q     <= ST_IDLE;
      cand_q      <= 2'd0;
      dir_q       <= 2'd0;
      qcnt_q      <= '0;
      hcnt_q      <= '0;
      ccnt_q      <= '0;
      en_q        <= 1'b0;
      conflict_q  <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      sync_meta_q <= {bp5, bp4, bp3, bp2, bp1};
      sync_q      <= sync_meta_q;
      state_q     <= state_d;
      cand_q      <= cand_d;
      dir_q       <= dir_d;
      qcnt_q      <= qcnt_d;
      hcnt_q      <= hcnt_d;
      ccnt_q      <= ccnt_d;
      en_q        <= en_d;
      conflict_q  <= conflict_d;
      timeout_q   <= timeout_d;
    end
  end

  assign td_en       = en_q;
  assign td_dir      = dir_q;
  assign td_conflict = conflict_q;
  assign td_timeout  = timeout_q;

endmodule

// File: tb/tb_tone_direction_decoder.sv
// tb_tone_direction_decoder
//   Directed bench for tone_direction_decoder with QUAL_CYCLES=4,
//   HOLD_CYCLES=20. Inputs change 1 time unit after a rising edge and
//   outputs are sampled at the same point, so "after edge n" is exact.
module tb_tone_direction_decoder;

  logic       clk;
  logic       rst_n;
  logic       bp1, bp2, bp3, bp4, bp5;
  logic       td_ack;
  logic       td_en;
  logic [1:0] td_dir;
  logic       td_conflict;
  logic       td_timeout;

  int n_chk;
  int n_bad;

  tone_direction_decoder #(
    .QUAL_CYCLES(4),
    .HOLD_CYCLES(20),
    .CNT_W      (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bp1        (bp1),
    .bp2        (bp2),
    .bp3        (bp3),
    .bp4        (bp4),
    .bp5        (bp5),
    .td_ack     (td_ack),
    .td_en      (td_en),
    .td_dir     (td_dir),
    .td_conflict(td_conflict),
    .td_timeout (td_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int cnt;
    int pulses;
    n_chk  = 0;
    n_bad  = 0;
    rst_n  = 1'b0;
    bp1 = 0; bp2 = 0; bp3 = 0; bp4 = 0; bp5 = 0;
    td_ack = 1'b0;

    // Reset state
    quiet(2);
    chk("rst_en", td_en, 0);
    chk("rst_dir", td_dir, 0);
    chk("rst_conflict", td_conflict, 0);
    chk("rst_timeout", td_timeout, 0);
    rst_n = 1'b1;
    quiet(3);

    // 1: RIGHT, latency QUAL+3 = 7 edges, ack at edge 10, no retrigger
    bp3 = 1;
    quiet(6);
    chk("t1_en_edge6", td_en, 0);
    tick();
    chk("t1_en_edge7", td_en, 1);
    chk("t1_dir", td_dir, 2);
    quiet(2);
    td_ack = 1;
    tick();
    td_ack = 0;
    chk("t1_en_after_ack", td_en, 0);
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (td_en) cnt++;
    end
    chk("t1_no_retrigger", cnt, 0);
    bp3 = 0;
    quiet(10);

    // 2: LEFT, no ack, hold for exactly 20 cycles then timeout pulse
    bp2 = 1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      cnt++;
      if (td_en) break;
    end
    chk("t2_latency", cnt, 7);
    chk("t2_dir", td_dir, 1);
    cnt = 1;
    pulses = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (td_en) begin
        cnt++;
        if (td_timeout) pulses++;
      end else break;
    end
    chk("t2_hold_len", cnt, 20);
    chk("t2_early_timeout", pulses, 0);
    chk("t2_timeout_pulse", td_timeout, 1);
    tick();
    chk("t2_timeout_one_cycle", td_timeout, 0);
    chk("t2_en_low", td_en, 0);
    chk("t2_dir_held", td_dir, 1);
    bp2 = 0;
    quiet(10);

    // 3: conflict, bp4 raised two cycles after bp1
    bp1 = 1;
    quiet(2);
    bp4 = 1;
    tick();
    chk("t3_conflict_e3", td_conflict, 0);
    tick();
    chk("t3_conflict_e4", td_conflict, 0);
    tick();
    chk("t3_conflict_e5", td_conflict, 1);
    cnt = 0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (td_en) cnt++;
      if (td_conflict) pulses++;
    end
    chk("t3_no_en", cnt, 0);
    chk("t3_single_conflict", pulses, 0);
    bp1 = 0;
    bp4 = 0;
    quiet(10);

    // 4: BACK valid, cancel drops td_en 4 cycles after s5 rises
    bp4 = 1;
    quiet(7);
    chk("t4_en", td_en, 1);
    chk("t4_dir", td_dir, 3);
    bp5 = 1;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (td_timeout || td_conflict) pulses++;
    end
    chk("t4_en_before_cancel", td_en, 1);
    tick();
    if (td_timeout || td_conflict) pulses++;
    chk("t4_en_cancelled", td_en, 0);
    chk("t4_no_pulses", pulses, 0);
    chk("t4_dir_held", td_dir, 3);
    bp4 = 0;
    quiet(3);
    bp5 = 0;
    quiet(10);

    // 5: short STRAIGHT blip does not qualify, long one does
    bp1 = 1;
    quiet(3);
    bp1 = 0;
    cnt = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (td_en) cnt++;
    end
    chk("t5_blip_no_en", cnt, 0);
    bp1 = 1;
    quiet(7);
    chk("t5_en", td_en, 1);
    chk("t5_dir", td_dir, 0);
    td_ack = 1;
    tick();
    td_ack = 0;
    chk("t5_ack", td_en, 0);
    bp1 = 0;
    quiet(10);

    // 6: asynchronous reset mid-VALID, then requalify
    bp2 = 1;
    quiet(7);
    chk("t6_en", td_en, 1);
    chk("t6_dir", td_dir, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_en", td_en, 0);
    chk("t6_async_dir", td_dir, 0);
    tick();
    rst_n = 1'b1;
    quiet(6);
    chk("t6_en_edge6", td_en, 0);
    tick();
    chk("t6_en_edge7", td_en, 1);
    chk("t6_dir_after", td_dir, 1);
    bp2 = 0;
    quiet(3);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
